// File: rtl/axi_bridge_pkg.sv
// Shared types for the Client-IF TX arbiter.
// Arbiter FSM states and counter widths.
package axi_bridge_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } arb_state_e;

    localparam int ARB_CNT_W = 32;
    localparam int WD_W      = 16;

endpackage

// File: rtl/axi_bridge_tx_arbiter_if.sv
// Segment bundle between ingress sources, the arbiter and cl_tx.
// slave = arbiter view, master = source/sink driver view.
interface axi_bridge_tx_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int IF_W    = 64,
    parameter int TUSER_W = 16
);
    logic [N_REQ*IF_W-1:0]     req_data;
    logic [N_REQ*IF_W/8-1:0]   req_keep;
    logic [N_REQ*TUSER_W-1:0]  req_user;
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_sop;
    logic [N_REQ-1:0]          req_eop;
    logic [N_REQ-1:0]          req_ready;

    logic [IF_W-1:0]           cl_tx_data;
    logic [IF_W/8-1:0]         cl_tx_keep;
    logic [TUSER_W-1:0]        cl_tx_user;
    logic                      cl_tx_sop;
    logic                      cl_tx_eop;
    logic                      cl_tx_valid;
    logic                      cl_tx_ready;

    modport slave (
        input  req_data, req_keep, req_user,
        input  req_valid, req_sop, req_eop,
        output req_ready,
        output cl_tx_data, cl_tx_keep, cl_tx_user,
        output cl_tx_sop, cl_tx_eop, cl_tx_valid,
        input  cl_tx_ready
    );

    modport master (
        output req_data, req_keep, req_user,
        output req_valid, req_sop, req_eop,
        input  req_ready,
        input  cl_tx_data, cl_tx_keep, cl_tx_user,
        input  cl_tx_sop, cl_tx_eop, cl_tx_valid,
        output cl_tx_ready
    );
endinterface

// File: rtl/axi_bridge_rr_pick.sv
// Rotating first-one picker: first set req bit at or after ptr.
// Purely combinational so the RX scheduler can reuse it.
module axi_bridge_rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);
    // Scan farthest-first so the nearest hit to ptr is the last write.
    always_comb begin
        gnt_idx = ptr;
        gnt_vld = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int s;
            s = int'(ptr) + k;
            if (s >= N) s = s - N;
            if (req[s]) begin
                gnt_idx = IW'(s);
                gnt_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/axi_bridge_tx_arbiter.sv
// Packet-atomic round-robin arbiter onto one Client-IF TX channel.
// Zero-latency mux; grants change only at packet boundaries.
module axi_bridge_tx_arbiter
    import axi_bridge_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int IF_W    = 64,
    parameter int TUSER_W = 16,
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    axi_bridge_tx_arbiter_if.slave     bus,
    input  logic                       arb_enable,
    input  logic [N_REQ-1:0]           req_mask,
    input  logic [15:0]                stall_thr,
    output logic [IDX_W-1:0]           stat_owner,
    output logic                       stat_busy,
    output logic [N_REQ*ARB_CNT_W-1:0] stat_pkt_cnt,
    output logic                       ev_err_stall,
    output logic                       ev_err_sop
);
    arb_state_e           state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     gnt_idx;
    logic [IDX_W-1:0]     nxt_ptr;
    logic                 pick_vld;
    logic                 gnt_vld;
    logic                 accept;
    logic                 owner_vld;
    logic [WD_W-1:0]      wd_cnt;
    logic [ARB_CNT_W-1:0] pkt_cnt [N_REQ];

    axi_bridge_rr_pick #(.N(N_REQ)) u_pick (
        .req     (bus.req_valid & req_mask),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    // Locked owner keeps the channel; otherwise the enabled winner.
    // Held in reset nothing is granted, so outputs drop at once.
    always_comb begin
        gnt_idx = pick_idx;
        gnt_vld = pick_vld & arb_enable;
        if (state == ARB_LOCK) begin
            gnt_idx = stat_owner;
            gnt_vld = 1'b1;
        end
        gnt_vld = gnt_vld & rst_ni;
    end

    // Zero-bubble pass-through of the granted source; zeros when idle.
    always_comb begin
        bus.cl_tx_data  = '0;
        bus.cl_tx_keep  = '0;
        bus.cl_tx_user  = '0;
        bus.cl_tx_sop   = 1'b0;
        bus.cl_tx_eop   = 1'b0;
        bus.cl_tx_valid = 1'b0;
        bus.req_ready   = '0;
        if (gnt_vld) begin
            bus.cl_tx_data  = bus.req_data[gnt_idx*IF_W +: IF_W];
            bus.cl_tx_keep  = bus.req_keep[gnt_idx*(IF_W/8) +: IF_W/8];
            bus.cl_tx_user  = bus.req_user[gnt_idx*TUSER_W +: TUSER_W];
            bus.cl_tx_sop   = bus.req_sop[gnt_idx];
            bus.cl_tx_eop   = bus.req_eop[gnt_idx];
            bus.cl_tx_valid = bus.req_valid[gnt_idx];
            bus.req_ready[gnt_idx] = bus.cl_tx_ready;
        end
    end

    assign accept    = bus.cl_tx_valid & bus.cl_tx_ready;
    assign owner_vld = bus.req_valid[stat_owner];
    assign nxt_ptr   = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0
                                                      : gnt_idx + IDX_W'(1);
    assign stat_busy = (state == ARB_LOCK);

    // Boundary FSM, framing check and stall watchdog (never breaks lock).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ARB_IDLE;
            rr_ptr       <= '0;
            stat_owner   <= '0;
            wd_cnt       <= '0;
            ev_err_stall <= 1'b0;
            ev_err_sop   <= 1'b0;
        end else begin
            ev_err_sop   <= accept & ((state == ARB_IDLE) ? ~bus.cl_tx_sop
                                                          : bus.cl_tx_sop);
            ev_err_stall <= 1'b0;
            if (accept) begin
                stat_owner <= gnt_idx;
                if (bus.cl_tx_eop) begin
                    state  <= ARB_IDLE;
                    rr_ptr <= nxt_ptr;
                end else begin
                    state  <= ARB_LOCK;
                end
            end
            if (state == ARB_LOCK && !owner_vld) begin
                if (wd_cnt != '1) begin
                    wd_cnt       <= wd_cnt + 1'b1;
                    ev_err_stall <= (stall_thr != '0) &&
                                    (wd_cnt + 16'd1 == stall_thr);
                end
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    // Per-source completed-packet counters, free-running with wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_REQ; i++) pkt_cnt[i] <= '0;
        end else if (accept && bus.cl_tx_eop) begin
            pkt_cnt[gnt_idx] <= pkt_cnt[gnt_idx] + 1'b1;
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_stat
        assign stat_pkt_cnt[i*ARB_CNT_W +: ARB_CNT_W] = pkt_cnt[i];
    end
endmodule

// File: tb/tb_axi_bridge_tx_arbiter.sv
// Random-traffic bench for axi_bridge_tx_arbiter.
// Packet-level reference model feeds a scoreboard queue.
module tb_axi_bridge_tx_arbiter;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic [15:0] user;
        logic        sop;
        logic        eop;
    } beat_t;

    typedef struct packed {
        logic [1:0] src;
        beat_t      b;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         arb_enable;
    logic [3:0]   req_mask;
    logic [15:0]  stall_thr;
    logic [1:0]   stat_owner;
    logic         stat_busy;
    logic [127:0] stat_pkt_cnt;
    logic         ev_err_stall;
    logic         ev_err_sop;

    axi_bridge_tx_arbiter_if #(.N_REQ(4), .IF_W(64), .TUSER_W(16)) bus ();

    axi_bridge_tx_arbiter #(.N_REQ(4), .IF_W(64), .TUSER_W(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .bus          (bus),
        .arb_enable   (arb_enable),
        .req_mask     (req_mask),
        .stall_thr    (stall_thr),
        .stat_owner   (stat_owner),
        .stat_busy    (stat_busy),
        .stat_pkt_cnt (stat_pkt_cnt),
        .ev_err_stall (ev_err_stall),
        .ev_err_sop   (ev_err_sop)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    bit    mon_on = 1'b0;
    exp_t  exp_q[$];
    exp_t  mon_e;
    beat_t src_q [4][$];

    bit       exp_valid_now = 1'b0;
    bit       exp_grant_now = 1'b0;
    bit [3:0] exp_rdy_now = '0;
    bit       exp_busy_now = 1'b0;
    int       exp_owner_now = 0;
    bit       exp_sop_now = 1'b0;
    bit       exp_stall_now = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Packet of 1..4 beats; occasionally a corrupted sop flag.
    task automatic gen_pkt(input int r);
        int len;
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) begin
            beat_t b;
            b.data = {$urandom, $urandom};
            b.keep = 8'($urandom);
            b.user = 16'($urandom);
            b.sop  = (j == 0);
            b.eop  = (j == len - 1);
            if ($urandom_range(0, 15) == 0) b.sop = ~b.sop;
            src_q[r].push_back(b);
        end
    endtask

    // Monitor: per-cycle status plus scoreboard pop on every accept.
    always @(negedge clk) begin
        #1;
        if (rst_ni && mon_on) begin
            chk("cl_tx_valid", 64'(bus.cl_tx_valid), 64'(exp_valid_now));
            chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy_now));
            chk("stat_busy", 64'(stat_busy), 64'(exp_busy_now));
            chk("stat_owner", 64'(stat_owner), 64'(exp_owner_now));
            chk("ev_err_sop", 64'(ev_err_sop), 64'(exp_sop_now));
            chk("ev_err_stall", 64'(ev_err_stall), 64'(exp_stall_now));
            if (!exp_grant_now) chk("idle_data", bus.cl_tx_data, 64'd0);
            if (bus.cl_tx_valid && bus.cl_tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected act=%h exp=none",
                             bus.cl_tx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("data", bus.cl_tx_data, mon_e.b.data);
                    chk("keep", 64'(bus.cl_tx_keep), 64'(mon_e.b.keep));
                    chk("user", 64'(bus.cl_tx_user), 64'(mon_e.b.user));
                    chk("sop", 64'(bus.cl_tx_sop), 64'(mon_e.b.sop));
                    chk("eop", 64'(bus.cl_tx_eop), 64'(mon_e.b.eop));
                    chk("src", 64'(bus.req_ready), 64'(4'b1 << mon_e.src));
                end
            end
        end
    end

    // Driver plus reference model: packet ownership, rotating priority.
    initial begin
        int    lock, owner_m, ptr, idle, g, hold;
        int    cnt_m [4];
        int    gap [4];
        bit    pend_sop, pend_stall, acc, did_rst, rdy;
        bit [3:0] vld;
        beat_t h [4];

        lock = -1; owner_m = 0; ptr = 0; idle = 0; hold = 0;
        pend_sop = 0; pend_stall = 0; did_rst = 0;
        for (int r = 0; r < 4; r++) begin
            cnt_m[r] = 0;
            gap[r] = 0;
        end

        arb_enable = 1'b1;
        req_mask = 4'hF;
        stall_thr = 16'd4;
        bus.req_data = {4{64'hA5A5_0000_FFFF_1234}};
        bus.req_keep = '1;
        bus.req_user = '1;
        bus.req_valid = 4'hF;
        bus.req_sop = 4'hF;
        bus.req_eop = 4'h0;
        bus.cl_tx_ready = 1'b1;

        #2;
        chk("rst_valid", 64'(bus.cl_tx_valid), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_busy", 64'(stat_busy), 64'd0);
        chk("rst_owner", 64'(stat_owner), 64'd0);
        chk("rst_cnt", stat_pkt_cnt[63:0], 64'd0);
        chk("rst_cnt_hi", stat_pkt_cnt[127:64], 64'd0);
        chk("rst_ev", 64'({ev_err_sop, ev_err_stall}), 64'd0);
        bus.req_valid = '0;
        #1 rst_ni = 1'b1;
        mon_on = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (hold > 0) begin
                hold--;
                if (hold > 0) continue;
                rst_ni = 1'b1;
            end
            if (!did_rst && cyc >= 1500 && lock >= 0) begin
                did_rst = 1'b1;
                rst_ni = 1'b0;
                exp_q.delete();
                for (int r = 0; r < 4; r++) begin
                    src_q[r].delete();
                    cnt_m[r] = 0;
                end
                lock = -1; owner_m = 0; ptr = 0; idle = 0;
                pend_sop = 0; pend_stall = 0;
                exp_valid_now = 0; exp_grant_now = 0; exp_rdy_now = '0;
                exp_busy_now = 0; exp_owner_now = 0;
                exp_sop_now = 0; exp_stall_now = 0;
                #1;
                chk("midrst_valid", 64'(bus.cl_tx_valid), 64'd0);
                chk("midrst_ready", 64'(bus.req_ready), 64'd0);
                chk("midrst_busy", 64'(stat_busy), 64'd0);
                chk("midrst_cnt", stat_pkt_cnt[63:0], 64'd0);
                hold = 3;
                continue;
            end

            if (cyc % 64 == 0) begin
                req_mask = 4'($urandom) | (4'b1 << $urandom_range(0, 3));
                arb_enable = ($urandom_range(0, 7) != 0);
                stall_thr = 16'($urandom_range(0, 8));
            end

            for (int r = 0; r < 4; r++) begin
                if (src_q[r].size() == 0) gen_pkt(r);
                h[r] = src_q[r][0];
                if (gap[r] > 0) begin
                    vld[r] = 1'b0;
                    gap[r]--;
                end else begin
                    if ($urandom_range(0, 39) == 0)
                        gap[r] = $urandom_range(3, 10);
                    vld[r] = ($urandom_range(0, 3) != 0);
                end
                bus.req_data[r*64 +: 64] = h[r].data;
                bus.req_keep[r*8 +: 8] = h[r].keep;
                bus.req_user[r*16 +: 16] = h[r].user;
                bus.req_sop[r] = h[r].sop;
                bus.req_eop[r] = h[r].eop;
            end
            bus.req_valid = vld;
            rdy = ($urandom_range(0, 3) != 0);
            bus.cl_tx_ready = rdy;

            g = -1;
            if (lock >= 0) g = lock;
            else if (arb_enable)
                for (int k = 0; k < 4; k++)
                    if (g < 0 && vld[(ptr + k) % 4] &&
                        req_mask[(ptr + k) % 4])
                        g = (ptr + k) % 4;
            acc = (g >= 0) && vld[g] && rdy;

            exp_grant_now = (g >= 0);
            exp_valid_now = (g >= 0) && vld[g];
            exp_rdy_now = (g >= 0 && rdy) ? (4'b1 << g) : 4'b0;
            exp_busy_now = (lock >= 0);
            exp_owner_now = owner_m;
            exp_sop_now = pend_sop;
            exp_stall_now = pend_stall;

            pend_sop = acc && ((lock < 0) ? !h[g].sop : h[g].sop);
            pend_stall = 1'b0;
            if (lock >= 0 && !vld[lock]) begin
                if (idle < 65535) begin
                    idle++;
                    pend_stall = (stall_thr != 0) && (idle == stall_thr);
                end
            end else begin
                idle = 0;
            end

            if (acc) begin
                exp_q.push_back('{src: 2'(g), b: h[g]});
                void'(src_q[g].pop_front());
                owner_m = g;
                if (h[g].eop) begin
                    cnt_m[g]++;
                    ptr = (g + 1) % 4;
                    lock = -1;
                end else begin
                    lock = g;
                end
            end
        end

        @(negedge clk);
        mon_on = 1'b0;
        bus.req_valid = '0;
        bus.cl_tx_ready = 1'b0;
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        chk("mid_reset_done", 64'(did_rst), 64'd1);
        for (int r = 0; r < 4; r++)
            chk("pkt_cnt", 64'(stat_pkt_cnt[r*32 +: 32]), 64'(cnt_m[r]));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
